// File: rtl/pwm_cfg_parser.sv
// Byte-stream frame decoder that drives the shared pwm_config_* broadcast bus.
// Define PWM_CFG_CHECKSUM_EN to add the trailing XOR checksum byte (12-byte frames).
module pwm_cfg_parser #(
    parameter int CHANNEL_NUM    = 8,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  rx_data,
    input  logic        rx_vld,
    output logic        pwm_config_vld,
    output logic [7:0]  pwm_config_channel,
    output logic        pwm_en,
    output logic [27:0] pwm_period,
    output logic [27:0] pwm_hlevel,
    output logic        frame_err,
    output logic [1:0]  err_code,
    output logic [7:0]  err_cnt
);
    localparam logic [7:0] HDR = 8'h55;
    localparam int GW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(TIMEOUT_CYCLES - 1);
`ifdef PWM_CFG_CHECKSUM_EN
    localparam int HW = 32;
`else
    localparam int HW = 24;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_CHAN, S_FLAGS, S_PER, S_HLV, S_CSUM, S_DONE
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    idx;
    logic [GW-1:0] gap;
    logic [7:0]    chan_sh;
    logic          en_sh;
    logic [31:0]   per_sh;
    logic [HW-1:0] hlv_sh;
    logic [31:0]   fin_hlv;
    logic          in_frame, timeout, last_byte;
    logic          csum_bad, chan_bad, range_bad;
    logic          cfg_ok, err_hit;
    logic [1:0]    code_nxt;

    assign in_frame = (state != S_IDLE) && (state != S_DONE);
    assign timeout  = in_frame && !rx_vld && (gap == GAP_LAST);

    // Validation happens on the edge taking the last byte so the strobe is live in DONE.
`ifdef PWM_CFG_CHECKSUM_EN
    logic [7:0] csum_sh;
    assign last_byte = rx_vld && (state == S_CSUM);
    assign fin_hlv   = hlv_sh;
    assign csum_bad  = (csum_sh != rx_data);
`else
    assign last_byte = rx_vld && (state == S_HLV) && (idx == 2'd3);
    assign fin_hlv   = {hlv_sh, rx_data};
    assign csum_bad  = 1'b0;
`endif
    assign chan_bad  = {24'd0, chan_sh} >= 32'(CHANNEL_NUM);
    assign range_bad = (per_sh[31:28] != 4'd0) || (per_sh == 32'd0)
                     || (fin_hlv > per_sh);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (timeout) begin
            state_nxt = S_IDLE;
        end else begin
            unique case (state)
                S_IDLE, S_DONE:
                    state_nxt = (rx_vld && rx_data == HDR) ? S_CHAN : S_IDLE;
                S_CHAN:  if (rx_vld) state_nxt = S_FLAGS;
                S_FLAGS: if (rx_vld) state_nxt = S_PER;
                S_PER:   if (rx_vld && idx == 2'd3) state_nxt = S_HLV;
                S_HLV: begin
                    if (rx_vld && idx == 2'd3) begin
`ifdef PWM_CFG_CHECKSUM_EN
                        state_nxt = S_CSUM;
`else
                        state_nxt = S_DONE;
`endif
                    end
                end
                S_CSUM:  if (rx_vld) state_nxt = S_DONE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cfg_ok   = 1'b0;
        err_hit  = 1'b0;
        code_nxt = 2'd0;
        if (timeout) begin
            err_hit  = 1'b1;
            code_nxt = 2'd3;
        end else if (last_byte) begin
            priority case (1'b1)
                csum_bad:  begin err_hit = 1'b1; code_nxt = 2'd0; end
                chan_bad:  begin err_hit = 1'b1; code_nxt = 2'd1; end
                range_bad: begin err_hit = 1'b1; code_nxt = 2'd2; end
                default:   cfg_ok = 1'b1;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx     <= 2'd0;
            gap     <= '0;
            chan_sh <= 8'd0;
            en_sh   <= 1'b0;
            per_sh  <= 32'd0;
            hlv_sh  <= '0;
        end else begin
            if (!in_frame || rx_vld || timeout) gap <= '0;
            else                                gap <= gap + 1'b1;
            if (rx_vld && (state == S_PER || state == S_HLV)) idx <= idx + 2'd1;
            else if (state != S_PER && state != S_HLV)        idx <= 2'd0;
            if (rx_vld) begin
                unique case (state)
                    S_CHAN:  chan_sh <= rx_data;
                    S_FLAGS: en_sh   <= rx_data[0];
                    S_PER:   per_sh  <= {per_sh[23:0], rx_data};
                    S_HLV:   hlv_sh  <= {hlv_sh[HW-9:0], rx_data};
                    default: ;
                endcase
            end
        end
    end

`ifdef PWM_CFG_CHECKSUM_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum_sh <= 8'd0;
        end else if (rx_vld) begin
            if (state == S_IDLE || state == S_DONE) csum_sh <= 8'd0;
            else if (state != S_CSUM)               csum_sh <= csum_sh ^ rx_data;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_config_vld     <= 1'b0;
            pwm_config_channel <= 8'd0;
            pwm_en             <= 1'b0;
            pwm_period         <= 28'd0;
            pwm_hlevel         <= 28'd0;
            frame_err          <= 1'b0;
            err_code           <= 2'd0;
            err_cnt            <= 8'd0;
        end else begin
            pwm_config_vld <= cfg_ok;
            frame_err      <= err_hit;
            if (cfg_ok) begin
                pwm_config_channel <= chan_sh;
                pwm_en             <= en_sh;
                pwm_period         <= per_sh[27:0];
                pwm_hlevel         <= fin_hlv[27:0];
            end
            if (err_hit) begin
                err_code <= code_nxt;
                if (err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_pwm_cfg_parser.sv
// Bench for pwm_cfg_parser: frame-level queue model checked every cycle,
// plus literal expectations for the directed cases.
module tb_pwm_cfg_parser;
    localparam int CH_N = 8;
    localparam int TO   = 16;
`ifdef PWM_CFG_CHECKSUM_EN
    localparam int FLEN = 12;
`else
    localparam int FLEN = 11;
`endif
    localparam int CS = FLEN - 11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_vld = 1'b0;
    logic        pwm_config_vld;
    logic [7:0]  pwm_config_channel;
    logic        pwm_en;
    logic [27:0] pwm_period;
    logic [27:0] pwm_hlevel;
    logic        frame_err;
    logic [1:0]  err_code;
    logic [7:0]  err_cnt;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pwm_cfg_parser #(.CHANNEL_NUM(CH_N), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_vld(rx_vld),
        .pwm_config_vld(pwm_config_vld),
        .pwm_config_channel(pwm_config_channel),
        .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_hlevel(pwm_hlevel),
        .frame_err(frame_err), .err_code(err_code), .err_cnt(err_cnt)
    );

    // Reference model: bytes of the open frame kept in a queue.
    logic [7:0]  mq[$];
    int          m_gap;
    logic        m_vld, m_err, m_en;
    logic [1:0]  m_code;
    logic [7:0]  m_cnt, m_ch;
    logic [27:0] m_per, m_hlv;

    task automatic m_reject(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
        if (m_cnt != 8'd255) m_cnt = m_cnt + 8'd1;
    endtask

    task automatic m_eval();
        logic [31:0] per, hl;
`ifdef PWM_CFG_CHECKSUM_EN
        logic [7:0] x;
        x = 8'd0;
        for (int i = 1; i <= 10; i++) x = x ^ mq[i];
        if (x != mq[11]) begin
            m_reject(2'd0);
            return;
        end
`endif
        per = {mq[3], mq[4], mq[5], mq[6]};
        hl  = {mq[7], mq[8], mq[9], mq[10]};
        if (int'(mq[1]) >= CH_N)
            m_reject(2'd1);
        else if (per[31:28] != 4'd0 || per == 32'd0 || hl > per)
            m_reject(2'd2);
        else begin
            m_vld = 1'b1;
            m_ch  = mq[1];
            m_en  = mq[2][0];
            m_per = per[27:0];
            m_hlv = hl[27:0];
        end
    endtask

    task automatic m_step();
        m_vld = 1'b0;
        m_err = 1'b0;
        if (rst) begin
            mq.delete();
            m_gap = 0; m_code = 2'd0; m_cnt = 8'd0; m_ch = 8'd0;
            m_en = 1'b0; m_per = 28'd0; m_hlv = 28'd0;
            return;
        end
        if (mq.size() > 0) begin
            if (rx_vld) begin
                mq.push_back(rx_data);
                m_gap = 0;
                if (mq.size() == FLEN) begin
                    m_eval();
                    mq.delete();
                end
            end else if (m_gap == TO - 1) begin
                m_reject(2'd3);
                mq.delete();
                m_gap = 0;
            end else begin
                m_gap++;
            end
        end else if (rx_vld && rx_data == 8'h55) begin
            mq.push_back(8'h55);
            m_gap = 0;
        end
    endtask

    initial forever begin
        @(posedge clk);
        m_step();
    end

    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if ({pwm_config_vld, pwm_config_channel, pwm_en, pwm_period,
                 pwm_hlevel, frame_err, err_code, err_cnt} !==
                {m_vld, m_ch, m_en, m_per, m_hlv, m_err, m_code, m_cnt}) begin
                errors++;
                $display("FAIL cycle t=%0t got vld=%b ch=%0d en=%b per=%0d hl=%0d err=%b code=%0d cnt=%0d exp vld=%b ch=%0d en=%b per=%0d hl=%0d err=%b code=%0d cnt=%0d",
                         $time, pwm_config_vld, pwm_config_channel, pwm_en,
                         pwm_period, pwm_hlevel, frame_err, err_code, err_cnt,
                         m_vld, m_ch, m_en, m_per, m_hlv, m_err, m_code, m_cnt);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] b);
        @(posedge clk);
        #2;
        rx_vld  = 1'b1;
        rx_data = b;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #2;
            rx_vld  = 1'b0;
            rx_data = 8'($urandom);
        end
    endtask

    task automatic send_frame(input logic [7:0] ch, input logic [7:0] fl,
                              input logic [31:0] per, input logic [31:0] hl,
                              input bit bad_cs, input int gap_max,
                              input int gap_at, input int gap_len);
        logic [7:0] f[12];
        logic [7:0] x;
        f[0] = 8'h55;
        f[1] = ch;
        f[2] = fl;
        for (int i = 0; i < 4; i++) begin
            f[3+i] = per[31-8*i -: 8];
            f[7+i] = hl[31-8*i -: 8];
        end
        x = 8'd0;
        for (int i = 1; i <= 10; i++) x = x ^ f[i];
        f[11] = x ^ {7'd0, bad_cs};
        for (int i = 0; i < FLEN; i++) begin
            drive(f[i]);
            if (i < FLEN - 1) begin
                if (i == gap_at)   idle(gap_len);
                else if (gap_max > 0) idle($urandom_range(0, gap_max));
            end
        end
    endtask

    task automatic frame(input logic [7:0] ch, input logic [31:0] per,
                         input logic [31:0] hl);
        send_frame(ch, 8'h01, per, hl, 1'b0, 0, -1, 0);
        idle(1);
    endtask

    logic [7:0]  r_ch, r_fl;
    logic [31:0] r_per, r_hl;
    int          r_sel, r_at, r_len;

    initial begin
        idle(3);
        chk("reset_out", {pwm_config_vld, frame_err, err_code, pwm_en,
                          pwm_config_channel, err_cnt}, 32'd0);
        chk("reset_per_hl", {4'd0, pwm_period} | {4'd0, pwm_hlevel}, 32'd0);
        rst = 1'b0;
        idle(2);

        frame(8'd2, 32'd100, 32'd25);
        chk("a_vld", pwm_config_vld, 1);
        chk("a_ch", pwm_config_channel, 2);
        chk("a_en", pwm_en, 1);
        chk("a_per", pwm_period, 100);
        chk("a_hl", pwm_hlevel, 25);
        chk("a_ferr", frame_err, 0);
`ifdef PWM_CFG_CHECKSUM_EN
        send_frame(8'd2, 8'h01, 32'd100, 32'd25, 1'b1, 0, -1, 0);
        idle(1);
        chk("cs_ferr", frame_err, 1);
        chk("cs_code", err_code, 0);
        chk("cs_cnt", err_cnt, 1);
        chk("cs_per", pwm_period, 100);
`endif
        frame(8'd8, 32'd100, 32'd25);
        chk("ch8_code", {frame_err, err_code}, {29'd0, 3'b101});
        chk("ch8_cnt", err_cnt, 1 + CS);
        frame(8'd1, 32'h1000_0000, 32'd0);
        chk("big_code", {frame_err, err_code}, {29'd0, 3'b110});
        frame(8'd1, 32'd50, 32'd51);
        chk("hl_gt_code", {frame_err, err_code}, {29'd0, 3'b110});
        chk("hl_gt_per", pwm_period, 100);
        frame(8'd1, 32'd50, 32'd50);
        chk("hl_eq_vld", pwm_config_vld, 1);
        chk("hl_eq_per", {pwm_period, 4'd0} | {4'd0, pwm_hlevel}, {28'd50, 4'd0} | 32'd50);

        drive(8'h00);
        drive(8'hAA);
        send_frame(8'd7, 8'h00, 32'd1000, 32'd0, 1'b0, 0, -1, 0);
        idle(1);
        chk("junk_vld", {pwm_config_vld, pwm_config_channel}, {23'd0, 1'b1, 8'd7});
        chk("junk_cnt", err_cnt, 3 + CS);

        drive(8'h55);
        drive(8'd3);
        idle(TO + 1);
        chk("to_ferr", frame_err, 1);
        chk("to_code", err_code, 3);
        chk("to_cnt", err_cnt, 4 + CS);
        frame(8'd1, 32'd10, 32'd5);
        chk("after_to_vld", pwm_config_vld, 1);
        send_frame(8'd4, 8'h01, 32'd20, 32'd7, 1'b0, 0, 1, TO - 1);
        idle(1);
        chk("edge15_vld", {pwm_config_vld, pwm_config_channel}, {23'd0, 1'b1, 8'd4});
        chk("edge15_cnt", err_cnt, 4 + CS);

        for (int n = 0; n < 250; n++) begin
            r_ch  = 8'($urandom_range(0, 9));
            r_fl  = 8'($urandom);
            r_sel = $urandom_range(0, 5);
            case (r_sel)
                0: r_per = 32'd0;
                1: r_per = {4'($urandom_range(1, 15)), 28'($urandom)};
                2: r_per = 32'h0FFF_FFFF;
                default: r_per = 32'($urandom_range(1, 300));
            endcase
            case ($urandom_range(0, 3))
                0: r_hl = r_per;
                1: r_hl = 32'd0;
                2: r_hl = r_per + 32'd1;
                default: r_hl = 32'($urandom_range(0, 300));
            endcase
            r_at  = ($urandom_range(0, 5) == 0) ? $urandom_range(0, FLEN - 2) : -1;
            r_len = $urandom_range(TO - 2, TO + 1);
            if ($urandom_range(0, 4) == 0) drive(8'($urandom));
            send_frame(r_ch, r_fl, r_per, r_hl, $urandom_range(0, 4) == 0,
                       ($urandom_range(0, 3) == 0) ? 2 : 0, r_at, r_len);
            idle($urandom_range(0, 2));
        end
        idle(TO + 4);

        for (int n = 0; n < 260; n++) send_frame(8'd9, 8'h01, 32'd10, 32'd1, 1'b0, 0, -1, 0);
        idle(1);
        chk("sat_cnt", err_cnt, 255);
        chk("sat_ferr", {frame_err, err_code}, {29'd0, 3'b101});

        drive(8'h55);
        drive(8'd1);
        drive(8'h01);
        drive(8'h00);
        @(posedge clk);
        #2;
        rst = 1'b1;
        rx_vld = 1'b0;
        #1;
        chk("rst_mid", {pwm_config_vld, frame_err, err_code, pwm_en,
                        pwm_config_channel, err_cnt}, 32'd0);
        chk("rst_mid_per", {4'd0, pwm_period} | {4'd0, pwm_hlevel}, 32'd0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        idle(TO + 4);
        chk("rst_no_err", err_cnt, 0);
        frame(8'd5, 32'd80, 32'd40);
        chk("rst_after_vld", {pwm_config_vld, pwm_config_channel}, {23'd0, 1'b1, 8'd5});
        idle(3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
